// File: rtl/smg_scan_module.sv
// Six-digit multiplexed 7-segment scanner. Each digit owns a slot of SCAN_DIV+1 clocks, and every slot
// opens with GUARD all-off clocks against ghosting. The shown value is latched once per frame.
module smg_scan_module #(
  parameter logic [22:0] SCAN_DIV = 23'd49_999,
  parameter int          GUARD    = 16,
  parameter int          BLANK_LZ = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] Number_Sig,
  input  logic [5:0]  Dot_Sig,
  output logic [7:0]  SMG_Data,
  output logic [5:0]  Scan_Sig,
  output logic        Frame_Done
);

  localparam logic [22:0] GUARD_C = 23'(GUARD);

  logic [22:0] c1_q, c1_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] num_q, num_d;
  logic [5:0]  dot_q, dot_d;
  logic [7:0]  seg_q, seg_d;
  logic [5:0]  scan_q, scan_d;
  logic        done_q, done_d;

  logic        slot_end;
  logic        frame_end;
  logic [3:0]  nib;
  logic [7:0]  pat;
  logic [6:1]  hi_zero;
  logic [5:0]  lz_blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  assign hi_zero[6]  = 1'b1;
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 5; gi >= 1; gi--) begin : g_lz
    if (gi < 6 && gi > 0) begin : g_bit
      if (gi == 5) begin : g_top
        assign hi_zero[gi] = (num_q[gi*4 +: 4] == 4'd0);
      end else begin : g_rest
        assign hi_zero[gi] = hi_zero[gi+1] & (num_q[gi*4 +: 4] == 4'd0);
      end
      assign lz_blank[gi] = (BLANK_LZ != 0) && hi_zero[gi];
    end
  end

  always_comb begin
    slot_end  = (c1_q == SCAN_DIV);
    frame_end = slot_end && (idx_q == 3'd5);

    c1_d  = slot_end ? 23'd0 : c1_q + 23'd1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    num_d  = frame_end ? Number_Sig : num_q;
    dot_d  = frame_end ? Dot_Sig    : dot_q;
    done_d = frame_end;

    nib = num_q[{idx_q, 2'b00} +: 4];
    pat = {dot_q[idx_q], lz_blank[idx_q] ? 7'h00 : seg7(nib)};

    if (c1_q < GUARD_C) begin
      seg_d  = 8'hFF;
      scan_d = 6'h3F;
    end else begin
      seg_d  = ~pat;
      scan_d = ~(6'b000001 << idx_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c1_q   <= 23'd0;
      idx_q  <= 3'd0;
      num_q  <= 24'd0;
      dot_q  <= 6'd0;
      seg_q  <= 8'hFF;
      scan_q <= 6'h3F;
      done_q <= 1'b0;
    end else begin
      c1_q   <= c1_d;
      idx_q  <= idx_d;
      num_q  <= num_d;
      dot_q  <= dot_d;
      seg_q  <= seg_d;
      scan_q <= scan_d;
      done_q <= done_d;
    end
  end

  assign SMG_Data   = seg_q;
  assign Scan_Sig   = scan_q;
  assign Frame_Done = done_q;

endmodule

// File: tb/tb_smg_scan_module.sv
// Randomized bench for smg_scan_module: a cycle-count based model predicts every output of every clock.
module tb_smg_scan_module;

  localparam int DIV   = 9;
  localparam int GRD   = 2;
  localparam int SLOTW = DIV + 1;
  localparam int FRAME = 6 * SLOTW;

  logic        clk;
  logic        rst;
  logic [23:0] num;
  logic [5:0]  dot;
  logic [7:0]  smg;
  logic [5:0]  scan;
  logic        done;

  smg_scan_module #(
    .SCAN_DIV (23'(DIV)),
    .GUARD    (GRD),
    .BLANK_LZ (1)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .Number_Sig (num),
    .Dot_Sig    (dot),
    .SMG_Data   (smg),
    .Scan_Sig   (scan),
    .Frame_Done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int k;          // clock edges since reset release
  int fr;         // frames completed (bench bookkeeping, survives resets)
  logic [23:0] sh_num;
  logic [5:0]  sh_dot;
  logic [6:0]  seg_tab [0:15];
  logic [23:0] val_a, val_b;
  logic [5:0]  dot_a, dot_b;
  bit          did_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
  endtask

  function automatic logic [7:0] exp_seg(input int c1, input int slot,
                                         input logic [23:0] v, input logic [5:0] d);
    logic [23:0] upper;
    logic [6:0]  p;
    if (c1 < GRD) return 8'hFF;
    upper = v >> (4 * slot);
    p = seg_tab[upper[3:0]];
    if (slot > 0 && upper == 24'd0) p = 7'h00;
    return ~{d[slot], p};
  endfunction

  function automatic logic [5:0] exp_scan(input int c1, input int slot);
    if (c1 < GRD) return 6'h3F;
    return 6'h3F ^ (6'd1 << slot);
  endfunction

  // Advance one clock and compare all outputs against the model.
  task automatic step();
    int s;
    @(posedge clk);
    #1;
    k++;
    s = k - 1;
    chk("seg",  {24'd0, smg},  {24'd0, exp_seg(s % SLOTW, (s / SLOTW) % 6, sh_num, sh_dot)});
    chk("scan", {26'd0, scan}, {26'd0, exp_scan(s % SLOTW, (s / SLOTW) % 6)});
    chk("done", {31'd0, done}, {31'd0, (k % FRAME) == 0});
    if (k % FRAME == 0) begin
      sh_num = num;
      sh_dot = dot;
      fr++;
      $display("frame %0d done: next shows %h dots %b", fr, sh_num, sh_dot);
    end
  endtask

  task automatic check_off(input string tag);
    chk({tag, "_seg"},  {24'd0, smg},  32'hFF);
    chk({tag, "_scan"}, {26'd0, scan}, 32'h3F);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  function automatic logic [23:0] rand_val();
    logic [23:0] v;
    int lz;
    if ($urandom_range(0, 3) == 0) return 24'($urandom);
    v = '0;
    for (int i = 0; i < 6; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    lz = $urandom_range(0, 6);
    for (int i = 0; i < 6; i++) if (i >= 6 - lz) v[i*4 +: 4] = 4'd0;
    return v;
  endfunction

  task automatic pick(input int f);
    dot_a = 6'd0;
    case (f)
      0: val_a = 24'h123456;
      1: val_a = 24'h000070;
      2: begin val_a = 24'h000000; dot_a = 6'b000100; end
      3: val_a = 24'h00000A;
      4: val_a = 24'h111111;
      5: val_a = 24'h111111;
      default: begin val_a = rand_val(); dot_a = 6'($urandom); end
    endcase
    val_b = val_a;
    dot_b = dot_a;
    if (f == 5) val_b = 24'h222222;
    else if (f > 5 && $urandom_range(0, 1) == 1) begin
      val_b = rand_val();
      dot_b = 6'($urandom);
    end
  endtask

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h40;

    n_chk = 0; n_pass = 0; k = 0; fr = 0; did_rst = 1'b0;
    sh_num = '0; sh_dot = '0;
    rst = 1'b1; num = '0; dot = '0;
    repeat (3) @(posedge clk);
    #1;
    check_off("reset");
    @(negedge clk);
    rst = 1'b0;

    while (fr < 14) begin
      step();
      if (k % FRAME == 1) begin
        pick(fr);
        num = val_a;
        dot = dot_a;
      end
      if (k % FRAME == 25) begin
        num = val_b;
        dot = dot_b;
      end
      if (fr == 8 && k % FRAME == 35 && !did_rst) begin
        did_rst = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_off("async_rst");
        @(posedge clk);
        #1;
        check_off("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        sh_num = '0;
        sh_dot = '0;
        $display("reset pulsed mid-frame, scan restarts");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
